spike_rate_encoder: RTL



---
 rtl/snn_pkg.sv | 18 +
 rtl/spike_accum_channel.sv | 41 ++++
 rtl/spike_rate_encoder.sv | 113 +++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared types and default sizes for the spiking front end.
//   SNN_PIXEL_W   : bits per pixel intensity
//   SNN_N_INPUTS  : channels per frame (28x28 image)
//   SNN_TIMESTEPS : spike vectors emitted per frame
package snn_pkg;

  localparam int unsigned SNN_PIXEL_W   = 8;
  localparam int unsigned SNN_N_INPUTS  = 784;
  localparam int unsigned SNN_TIMESTEPS = 16;

  typedef logic [SNN_PIXEL_W-1:0] pixel_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } enc_state_t;

endpackage

// File: rtl/spike_accum_channel.sv
// One rate-coding channel: latched pixel plus a phase accumulator. The carry out of
// acc + pix is the spike for the current step; the sum becomes the new phase when the
// step is consumed.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_load      : frame accepted, latch i_pix and load INIT into the accumulator
//   i_advance   : current step consumed, accumulator takes the sum
//   i_pix       : pixel intensity for this channel
//   o_carry     : spike bit for the current step (combinational from registers)
module spike_accum_channel #(
  parameter int unsigned          PIXEL_W = 8,
  parameter logic [PIXEL_W-1:0]   INIT    = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_advance,
  input  logic [PIXEL_W-1:0] i_pix,
  output logic               o_carry
);

  logic [PIXEL_W-1:0] r_pix;
  logic [PIXEL_W-1:0] r_acc;
  logic [PIXEL_W:0]   w_sum;

  assign w_sum   = {1'b0, r_acc} + {1'b0, r_pix};
  assign o_carry = w_sum[PIXEL_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix <= '0;
      r_acc <= '0;
    end else if (i_load) begin
      r_pix <= i_pix;
      r_acc <= INIT;
    end else if (i_advance) begin
      r_acc <= w_sum[PIXEL_W-1:0];
    end
  end

endmodule

// File: rtl/spike_rate_encoder.sv
// Deterministic rate encoder: accepts one frame of pixels and emits TIMESTEPS spike
// vectors over a valid/ready interface, then returns to IDLE for the next frame.
// Build option ENC_PHASE_OFFSET_EN: when defined, accumulators start at half scale so the
// per-frame spike count rounds to nearest; otherwise they start at zero (truncating).
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   pix_valid/pix_ready   : frame handshake (ready only in IDLE)
//   pix_data              : channel i = pix_data[i*PIXEL_W +: PIXEL_W]
//   spike_valid/ready     : step handshake (valid throughout RUN)
//   spikes                : spike bit per channel for the current step
//   step_idx, last_step   : current step index, final-step flag
//   busy                  : high while a frame is being emitted
module spike_rate_encoder
  import snn_pkg::*;
#(
  parameter int unsigned N_INPUTS  = SNN_N_INPUTS,
  parameter int unsigned PIXEL_W   = SNN_PIXEL_W,
  parameter int unsigned TIMESTEPS = SNN_TIMESTEPS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pix_valid,
  output logic                          pix_ready,
  input  logic [N_INPUTS*PIXEL_W-1:0]   pix_data,
  output logic                          spike_valid,
  input  logic                          spike_ready,
  output logic [N_INPUTS-1:0]           spikes,
  output logic [$clog2(TIMESTEPS)-1:0]  step_idx,
  output logic                          last_step,
  output logic                          busy
);

  localparam int unsigned           STEP_W    = $clog2(TIMESTEPS);
  localparam logic [STEP_W-1:0]     LAST_STEP = STEP_W'(TIMESTEPS - 1);

`ifdef ENC_PHASE_OFFSET_EN
  localparam logic [PIXEL_W-1:0] INIT_PHASE = {1'b1, {(PIXEL_W-1){1'b0}}};
`else
  localparam logic [PIXEL_W-1:0] INIT_PHASE = '0;
`endif

  enc_state_t          r_state, w_state_next;
  logic [STEP_W-1:0]   r_step, w_step_next;
  logic                w_accept;
  logic                w_fire;
  logic                w_last;
  logic [N_INPUTS-1:0] w_carry;

  assign w_accept = pix_valid && (r_state == IDLE);
  assign w_fire   = (r_state == RUN) && spike_ready;
  assign w_last   = (r_state == RUN) && (r_step == LAST_STEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_step  <= '0;
    end else begin
      r_state <= w_state_next;
      r_step  <= w_step_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_step_next  = r_step;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = RUN;
          w_step_next  = '0;
        end
      end
      RUN: begin
        if (w_fire) begin
          if (w_last) begin
            // Step counter only wraps by leaving RUN.
            w_state_next = IDLE;
            w_step_next  = '0;
          end else begin
            w_step_next = r_step + STEP_W'(1);
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_step_next  = '0;
      end
    endcase
  end

  for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_ch
    spike_accum_channel #(
      .PIXEL_W (PIXEL_W),
      .INIT    (INIT_PHASE)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_load    (w_accept),
      .i_advance (w_fire),
      .i_pix     (pix_data[gi*PIXEL_W +: PIXEL_W]),
      .o_carry   (w_carry[gi])
    );
  end

  assign pix_ready   = (r_state == IDLE);
  assign spike_valid = (r_state == RUN);
  assign busy        = (r_state == RUN);
  assign step_idx    = r_step;
  assign last_step   = w_last;
  // Pixel regs persist after a frame; mask so IDLE always shows no spikes.
  assign spikes      = w_carry & {N_INPUTS{spike_valid}};

endmodule
